comp_result_tracker: RTL and testbench

- Downstream consumer of the 4-bit magnitude comparator's GT/LT/EQ outputs.
- Samples one comparison result per accepted handshake and tracks the committed A-vs-B relationship with a persistence filter, so a result must repeat before the reported relationship changes.
- Emits a one-cycle change event and a sticky flag for malformed (non-one-hot) results.
- Sits between the comparator and the control logic that acts on comparison trends.

---
 rtl/comp_result_tracker.sv | 191 +++++++++++++++++++
 tb/tb_comp_result_tracker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/comp_result_tracker.sv
// comp_result_tracker
//
// Purpose:
//   Consumes GT/LT/EQ results from a 4-bit magnitude comparator, one per
//   accepted handshake, and reports the committed A-vs-B relationship through
//   a persistence filter. A relationship that differs from the committed one
//   must be seen PERSIST times in a row before it replaces it. The first legal
//   sample after reset or clear commits immediately. Non-one-hot samples set a
//   sticky flag and break any run in progress.
//
// Handshake:
//   A sample is taken on a rising edge where in_valid=1 and in_ready=1.
//   in_ready is registered and drops for one cycle after reset and after clr.
//   G/L/E are ignored on all other edges.
//
// Optional feature:
//   Define COMP_TRACK_CNT_EN to build the per-outcome saturating counters
//   (gt_cnt, lt_cnt, eq_cnt). Without it the counter ports do not exist.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   a comparator result is presented on G/L/E
//   in_ready  out  block can accept a sample
//   G, L, E   in   comparator greater / less / equal results
//   clr       in   synchronous soft clear (wins over a same-edge sample)
//   state     out  committed relationship: 00 UNKNOWN, 01 LESS, 10 EQUAL, 11 GREATER
//   changed   out  one-cycle pulse coincident with a newly committed state
//   illegal   out  sticky flag, set by a non-one-hot accepted sample
//   gt_cnt    out  accepted GREATER samples (COMP_TRACK_CNT_EN only)
//   lt_cnt    out  accepted LESS samples    (COMP_TRACK_CNT_EN only)
//   eq_cnt    out  accepted EQUAL samples   (COMP_TRACK_CNT_EN only)

module comp_result_tracker #(
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             G,
    input  logic             L,
    input  logic             E,
    input  logic             clr,
    output logic [1:0]       state,
    output logic             changed,
    output logic             illegal
`ifdef COMP_TRACK_CNT_EN
    ,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt
`endif
);

    // The run counter is 4 bits, so the threshold is clamped to 1..15.
    localparam int P_CLAMP = (PERSIST < 1) ? 1 : ((PERSIST > 15) ? 15 : PERSIST);
    localparam logic [3:0] P_THR = 4'(P_CLAMP);

    typedef enum logic [1:0] {
        REL_UNKNOWN = 2'b00,
        REL_LESS    = 2'b01,
        REL_EQUAL   = 2'b10,
        REL_GREATER = 2'b11
    } rel_t;

    rel_t       state_q, state_d;
    rel_t       cand_q, cand_d;
    logic [3:0] run_q, run_d;
    logic       changed_q, changed_d;
    logic       illegal_q, illegal_d;
    logic       ready_q, ready_d;

    rel_t       outcome;
    logic       legal;
    logic       accept;
    logic [3:0] run_inc;

    // Decode the comparator bits; anything other than one-hot is illegal.
    always_comb begin
        outcome = REL_UNKNOWN;
        legal   = 1'b1;
        case ({G, L, E})
            3'b100:  outcome = REL_GREATER;
            3'b010:  outcome = REL_LESS;
            3'b001:  outcome = REL_EQUAL;
            default: legal   = 1'b0;
        endcase
    end

    assign accept  = in_valid & ready_q;
    // run_q never exceeds P_THR-1 (at most 14), so this cannot wrap.
    assign run_inc = run_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= REL_UNKNOWN;
            cand_q    <= REL_UNKNOWN;
            run_q     <= 4'd0;
            changed_q <= 1'b0;
            illegal_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            changed_q <= changed_d;
            illegal_q <= illegal_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        run_d     = run_q;
        changed_d = 1'b0;
        illegal_d = illegal_q;
        ready_d   = ~clr;

        if (clr) begin
            // Clear discards any sample presented on the same edge.
            state_d   = REL_UNKNOWN;
            cand_d    = REL_UNKNOWN;
            run_d     = 4'd0;
            illegal_d = 1'b0;
        end else if (accept) begin
            if (!legal) begin
                illegal_d = 1'b1;
                cand_d    = REL_UNKNOWN;
                run_d     = 4'd0;
            end else if (state_q == REL_UNKNOWN) begin
                // No relationship known yet: take the first legal result as is.
                state_d   = outcome;
                cand_d    = outcome;
                run_d     = 4'd0;
                changed_d = 1'b1;
            end else if (outcome == state_q) begin
                cand_d = state_q;
                run_d  = 4'd0;
            end else if (outcome == cand_q) begin
                if (run_inc == P_THR) begin
                    state_d   = outcome;
                    run_d     = 4'd0;
                    changed_d = 1'b1;
                end else begin
                    run_d = run_inc;
                end
            end else begin
                cand_d = outcome;
                run_d  = 4'd1;
                if (P_THR == 4'd1) begin
                    state_d   = outcome;
                    run_d     = 4'd0;
                    changed_d = 1'b1;
                end
            end
        end
    end

    assign state    = state_q;
    assign changed  = changed_q;
    assign illegal  = illegal_q;
    assign in_ready = ready_q;

`ifdef COMP_TRACK_CNT_EN
    logic [CNT_W-1:0] gt_q, lt_q, eq_q;
    logic             cnt_en;

    // Counters see every accepted legal sample, committing or not.
    assign cnt_en = accept & legal & ~clr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            gt_q <= '0;
            lt_q <= '0;
            eq_q <= '0;
        end else if (cnt_en) begin
            if (outcome == REL_GREATER && gt_q != '1) gt_q <= gt_q + 1'b1;
            if (outcome == REL_LESS    && lt_q != '1) lt_q <= lt_q + 1'b1;
            if (outcome == REL_EQUAL   && eq_q != '1) eq_q <= eq_q + 1'b1;
        end
    end

    assign gt_cnt = gt_q;
    assign lt_cnt = lt_q;
    assign eq_cnt = eq_q;
`endif

endmodule

// File: tb/tb_comp_result_tracker.sv
module tb_comp_result_tracker;

    localparam int CNT_W = 2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       G, L, E;
    logic       clr;
    logic [1:0] state;
    logic       changed;
    logic       illegal;
`ifdef COMP_TRACK_CNT_EN
    logic [CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt;
`endif

    comp_result_tracker #(
        .PERSIST (3),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .G        (G),
        .L        (L),
        .E        (E),
        .clr      (clr),
        .state    (state),
        .changed  (changed),
        .illegal  (illegal)
`ifdef COMP_TRACK_CNT_EN
        ,
        .gt_cnt   (gt_cnt),
        .lt_cnt   (lt_cnt),
        .eq_cnt   (eq_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    // Inputs for one edge and the outputs expected just after that edge.
    typedef struct packed {
        logic       v;
        logic       g;
        logic       l;
        logic       e;
        logic       c;
        logic [1:0] st;
        logic       chg;
        logic       ill;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    // Scoreboard: {state, changed, illegal, in_ready}
    logic [4:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic v, input logic g, input logic l,
                                input logic e, input logic c, input logic [1:0] st,
                                input logic chg, input logic ill, input logic rdy);
        vec_t t;
        t.v = v; t.g = g; t.l = l; t.e = e; t.c = c;
        t.st = st; t.chg = chg; t.ill = ill; t.rdy = rdy;
        return t;
    endfunction

    task automatic check_out(input string name);
        logic [4:0] got;
        logic [4:0] exp;
        got = {state, changed, illegal, in_ready};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got state=%b changed=%b illegal=%b in_ready=%b, expected state=%b changed=%b illegal=%b in_ready=%b",
                         name, got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Called on a falling edge; drives one edge of stimulus, checks, returns on the next falling edge.
    task automatic apply(input vec_t t, input string name);
        in_valid = t.v;
        G        = t.g;
        L        = t.l;
        E        = t.e;
        clr      = t.c;
        exp_q.push_back({t.st, t.chg, t.ill, t.rdy});
        @(posedge clk);
        #1;
        check_out(name);
        @(negedge clk);
    endtask

    task automatic reset_step(input string name);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        G = 1'b0; L = 1'b0; E = 1'b0;
        clr      = 1'b0;
        exp_q.push_back({2'b00, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        check_out(name);
        @(negedge clk);
    endtask

    // ---------------- test ----------------
    initial begin
        //                v  g  l  e  c  st     chg ill rdy
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'b00, 0, 0, 1)); // 0 ready low after reset: ignored
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'b10, 1, 0, 1)); // 1 E from UNKNOWN commits
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 1)); // 2 pulse is one cycle
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 1)); // 3 G run 1
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 1)); // 4 G run 2
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b11, 1, 0, 1)); // 5 G run 3 commits
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 1)); // 6
        tbl.push_back(mk(1, 0, 1, 0, 0, 2'b11, 0, 0, 1)); // 7 L
        tbl.push_back(mk(1, 0, 1, 0, 0, 2'b11, 0, 0, 1)); // 8 L
        tbl.push_back(mk(1, 0, 1, 0, 0, 2'b01, 1, 0, 1)); // 9 L commits LESS
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 0, 1)); // 10 G
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 0, 1)); // 11 G
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'b01, 0, 0, 1)); // 12 E breaks the run
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 0, 1)); // 13 G run 1
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 0, 1)); // 14 G run 2
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'b01, 0, 0, 1)); // 15 E breaks again
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 0, 1)); // 16 G
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 0, 1)); // 17 G
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b11, 1, 0, 1)); // 18 G commits GREATER
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b11, 0, 0, 1)); // 19 same as state: no event
        tbl.push_back(mk(1, 1, 1, 0, 0, 2'b11, 0, 1, 1)); // 20 G+L illegal
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'b11, 0, 1, 1)); // 21 no bit set: illegal stays
        tbl.push_back(mk(1, 0, 0, 1, 1, 2'b00, 0, 0, 0)); // 22 clr beats same-edge sample
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'b00, 0, 0, 1)); // 23 ready low after clr: ignored
        tbl.push_back(mk(1, 0, 1, 0, 0, 2'b01, 1, 0, 1)); // 24 L commits from UNKNOWN
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 0, 1)); // 25 G run 1
        tbl.push_back(mk(1, 1, 0, 1, 0, 2'b01, 0, 1, 1)); // 26 G+E illegal, run cleared
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 1, 1)); // 27 G run 1 again
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b01, 0, 1, 1)); // 28 G run 2
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b11, 1, 1, 1)); // 29 G commits, illegal sticky
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b11, 0, 1, 1)); // 30
        tbl.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0)); // 31 clr alone
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 1)); // 32 bad bits without valid
        tbl.push_back(mk(1, 0, 0, 1, 0, 2'b10, 1, 0, 1)); // 33 E commits
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 1)); // 34 G run 1
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 1)); // 35 G run 2

        rst_n    = 1'b0;
        in_valid = 1'b0;
        G = 1'b0; L = 1'b0; E = 1'b0;
        clr      = 1'b0;
        @(negedge clk);
        reset_step("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a G run.
        reset_step("reset_mid_run");
        rst_n = 1'b1;
        apply(mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 1), "post_reset_ignored");
        apply(mk(1, 1, 0, 0, 0, 2'b11, 1, 0, 1), "post_reset_commit");
        apply(mk(1, 0, 0, 1, 0, 2'b11, 0, 0, 1), "post_reset_e1");
        apply(mk(1, 0, 0, 1, 0, 2'b11, 0, 0, 1), "post_reset_e2");
        apply(mk(1, 0, 0, 1, 0, 2'b10, 1, 0, 1), "post_reset_e3");

`ifdef COMP_TRACK_CNT_EN
        apply(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0), "cnt_clr");
        check_val("gt_cnt_cleared", int'(gt_cnt), 0);
        check_val("eq_cnt_cleared", int'(eq_cnt), 0);
        apply(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 1), "cnt_idle");
        apply(mk(1, 1, 0, 0, 0, 2'b11, 1, 0, 1), "cnt_g1");
        check_val("gt_cnt_1", int'(gt_cnt), 1);
        for (int k = 2; k <= 5; k++) apply(mk(1, 1, 0, 0, 0, 2'b11, 0, 0, 1), $sformatf("cnt_g%0d", k));
        check_val("gt_cnt_sat", int'(gt_cnt), 3);
        check_val("lt_cnt_zero", int'(lt_cnt), 0);
        check_val("eq_cnt_zero", int'(eq_cnt), 0);
        apply(mk(1, 0, 1, 0, 0, 2'b11, 0, 0, 1), "cnt_l1");
        apply(mk(1, 1, 1, 0, 0, 2'b11, 0, 1, 1), "cnt_illegal");
        check_val("lt_cnt_1", int'(lt_cnt), 1);
        check_val("gt_cnt_hold", int'(gt_cnt), 3);
`endif

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
